// File: rtl/dice_roll_controller.sv
// ============================================================================
// Module   : dice_roll_controller
// Brief    : Debounced roll button sequencer for the craps game FSM. Runs a
//            timed tumble, latches two die values from free-running counters,
//            presents their sum and emits a one-cycle roll strobe.
// Options  : ROLL_ANIM_EN - when defined, Die1/Die2 tumble during ROLLING
//            and are restored to their pre-roll values on an abort.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dice_roll_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ROLL_CYCLES     = 25_000_000
) (
  input  logic       Clk100MHz,
  input  logic       reset,
  input  logic       RollButton,
  input  logic       GameOver,
  output logic [2:0] Die1,
  output logic [2:0] Die2,
  output logic [3:0] DiceSum,
  output logic       DiceRolled,
  output logic       Busy,
  output logic [7:0] RollCount
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RC_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] ROLL_LAST = RC_W'(ROLL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ROLLING      = 2'd1,
    REPORT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic            btn_meta;
  logic            btn_s;
  logic            btn_db;
  logic            btn_db_prev;
  logic [DB_W-1:0] db_cnt;
  logic [RC_W-1:0] roll_cnt;
  logic [2:0]      f1;
  logic [2:0]      f2;
  logic            press;

`ifdef ROLL_ANIM_EN
  logic [2:0]      save_d1;
  logic [2:0]      save_d2;
`endif

  // A press is the rising edge of the debounced level, seen one cycle late.
  assign press = btn_db & ~btn_db_prev;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge Clk100MHz or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= RollButton;
      btn_s    <= btn_meta;
    end
  end

  // Accept a new button level only after it has differed for the full window.
  always_ff @(posedge Clk100MHz or posedge reset) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_db      <= 1'b0;
      btn_db_prev <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Free-running dice: f1 spins every clock, f2 steps when f1 wraps.
  always_ff @(posedge Clk100MHz or posedge reset) begin
    if (reset) begin
      f1 <= 3'd1;
      f2 <= 3'd1;
    end else begin
      f1 <= (f1 == 3'd6) ? 3'd1 : f1 + 3'd1;
      if (f1 == 3'd6) begin
        f2 <= (f2 == 3'd6) ? 3'd1 : f2 + 3'd1;
      end
    end
  end

  // Roll sequencer; every output is registered here.
  always_ff @(posedge Clk100MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      roll_cnt   <= '0;
      Die1       <= 3'd0;
      Die2       <= 3'd0;
      DiceSum    <= 4'd0;
      DiceRolled <= 1'b0;
      Busy       <= 1'b0;
      RollCount  <= 8'd0;
`ifdef ROLL_ANIM_EN
      save_d1    <= 3'd0;
      save_d2    <= 3'd0;
`endif
    end else begin
      DiceRolled <= 1'b0;
      case (state)
        IDLE: begin
          if (press && !GameOver) begin
            state    <= ROLLING;
            roll_cnt <= '0;
            Busy     <= 1'b1;
`ifdef ROLL_ANIM_EN
            save_d1  <= Die1;
            save_d2  <= Die2;
`endif
          end
        end
        ROLLING: begin
          // Abort has priority over a latch landing on the same cycle.
          if (GameOver) begin
            state <= WAIT_RELEASE;
`ifdef ROLL_ANIM_EN
            Die1  <= save_d1;
            Die2  <= save_d2;
`endif
          end else if (roll_cnt == ROLL_LAST) begin
            Die1       <= f1;
            Die2       <= f2;
            DiceSum    <= {1'b0, f1} + {1'b0, f2};
            DiceRolled <= 1'b1;
            if (RollCount != 8'hFF) begin
              RollCount <= RollCount + 8'd1;
            end
            state      <= REPORT;
          end else begin
            roll_cnt <= roll_cnt + 1'b1;
`ifdef ROLL_ANIM_EN
            Die1     <= f1;
            Die2     <= f2;
`endif
          end
        end
        REPORT: begin
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!btn_db) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/dice_roll_controller.md
# dice_roll_controller

Sequencer that drives the dice inputs of the craps game state machine. It synchronizes and debounces the raw roll pushbutton and runs a timed tumble. It then latches two die values, presents their sum, and issues a single-cycle roll strobe. Instantiated between the board button and the game FSM, it guarantees exactly one roll event per physical press, with DiceSum stable whenever the strobe is high.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 2.
- ROLL_CYCLES, 25_000_000: cycles spent in ROLLING before latching (250 ms); minimum 1.

Ports:
- Clk100MHz  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- RollButton  in  1  raw pushbutton, asynchronous, bouncy.
- GameOver  in  1  high when the game FSM has reached its end state; blocks and aborts rolls.
- Die1  out  3  latched die 1 value, 1..6, 0 before first roll.
- Die2  out  3  latched die 2 value, 1..6, 0 before first roll.
- DiceSum  out  4  Die1+Die2, 2..12, 0 before first roll.
- DiceRolled  out  1  one-cycle strobe, new DiceSum valid.
- Busy  out  1  high whenever state is not IDLE.
- RollCount  out  8  number of DiceRolled strobes since reset, saturates at 255.

## Operation
- Synchronizer: 2-FF chain on RollButton, giving btn_s.
- Debouncer: the counter clears whenever btn_s equals btn_db. Otherwise it increments. When btn_s has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles, btn_db takes btn_s and the counter clears. A press event is a 0→1 transition of btn_db.
- Free-running dice counters run in every state:
  - f1 cycles 1,2,…,6,1 every clock.
  - f2 advances 1..6 only on the cycle f1 wraps 6→1.
  - Both reset to 1.
  - After k clock edges since reset release: f1 = 1+(k mod 6), f2 = 1+(⌊k/6⌋ mod 6).
- State machine:
  - IDLE: on a press event with GameOver=0, go to ROLLING and clear the roll counter. With GameOver=1 the press is ignored and the machine stays in IDLE.
  - ROLLING: the roll counter increments each cycle. If GameOver=1, go to WAIT_RELEASE with no latch and no strobe. Otherwise, when the counter equals ROLL_CYCLES-1:
    - Die1←f1 and Die2←f2 (values present in that cycle).
    - DiceSum←f1+f2, zero-extended 3-bit addition into 4 bits.
    - Go to REPORT.
  - REPORT: DiceRolled=1 for exactly this one cycle, and RollCount increments unless it is 255. Go to WAIT_RELEASE.
  - WAIT_RELEASE: when btn_db=0, go to IDLE. Holding the button never produces a second roll.
- Die1, Die2 and DiceSum hold their values until the next latch. An aborted roll leaves them unchanged.
- All outputs are registered.

## Timing
- Reset values: Die1=0, Die2=0, DiceSum=0, DiceRolled=0, Busy=0, RollCount=0, state IDLE, f1=f2=1, btn_db=0.
- Latency from a clean RollButton rise to entry into ROLLING: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- The latch happens ROLL_CYCLES cycles after entering ROLLING. DiceRolled is high the cycle after the latch.
- DiceSum changes only on the same edge that raises DiceRolled, and is stable for at least the strobe cycle and every cycle after it until the next latch.
- Busy rises the cycle after the press event and falls on the cycle after btn_db=0 is seen in WAIT_RELEASE.
- If GameOver rises in the same cycle the ROLLING counter reaches ROLL_CYCLES-1, the abort wins: no latch and no strobe.
- An asynchronous reset at any point immediately forces all reset values, including mid-ROLLING and during REPORT. No strobe is emitted afterward.

## Configuration
- ROLL_ANIM_EN defined: during ROLLING, Die1/Die2 follow f1/f2 every cycle so the displays tumble. DiceSum still changes only at the latch. On an abort, Die1/Die2 revert to their pre-roll values on entry to WAIT_RELEASE.
- ROLL_ANIM_EN undefined: Die1/Die2 change only at the latch.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and ROLL_CYCLES=8.
- Clean press: hold the button 40 cycles, then release. Required: exactly one DiceRolled pulse of 1 cycle, DiceSum=Die1+Die2 within 2..12, RollCount=1, and Busy falls 2+4+1 cycles after the release.
- Bounce: RollButton toggles every 2 cycles for 20 cycles, then is held high 30 cycles. Required: exactly one DiceRolled, and no event during the toggling.
- Determinism: time the press so the latch cycle has k=13. Required: Die1=2, Die2=3, DiceSum=5. Repeat with a latch at k=35. Required: Die1=6, Die2=6, DiceSum=12.
- Hold/re-press plus GameOver:
  - Hold 100 cycles: one strobe only.
  - Press with GameOver=1: no strobe and Busy stays 0.
  - Raise GameOver at the 3rd ROLLING cycle: no strobe, outputs unchanged, WAIT_RELEASE then IDLE after release.
- Reset and saturation:
  - Assert reset mid-ROLLING: all outputs return to reset values in the same cycle, and no strobe follows.
  - Perform 260 rolls: RollCount stays at 255.
